// File: rtl/ras_if.sv
// ras_if: request/response bundle between the branch predictor (master) and
// the return-address-stack controller (slave).
interface ras_if #(
    parameter int WIDTH = 36
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_addr;
    logic             ready;
    logic [WIDTH-1:0] top_addr;
    logic             top_valid;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, push_addr,
        input  ready, top_addr, top_valid, overflow, underflow
    );

    modport slave (
        input  push, pop, push_addr,
        output ready, top_addr, top_valid, overflow, underflow
    );
endinterface

// File: rtl/ras_ctrl.sv
// ras_ctrl: return-address-stack controller with a cached top entry and a
// below-top prefetch on BRAM port B. Define RAS_CKPT_EN for checkpoint/restore.
module ras_ctrl #(
    parameter  int DEPTH = 1024,
    parameter  int WIDTH = 36,
    localparam int ADDR  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    ras_if.slave             bus,
`ifdef RAS_CKPT_EN
    input  logic             ckpt_save,
    input  logic             ckpt_restore,
`endif
    output logic             bram_rea,
    output logic             bram_reb,
    output logic             bram_wea,
    output logic             bram_web,
    output logic [ADDR-1:0]  bram_raddra,
    output logic [ADDR-1:0]  bram_raddrb,
    output logic [ADDR-1:0]  bram_waddra,
    output logic [ADDR-1:0]  bram_waddrb,
    output logic [WIDTH-1:0] bram_wia,
    output logic [WIDTH-1:0] bram_wib,
    input  logic [WIDTH-1:0] bram_doa,
    input  logic [WIDTH-1:0] bram_dob
);

    localparam logic [ADDR-1:0] TOS_ONE  = ADDR'(1);
    localparam logic [ADDR:0]   CNT_ONE  = (ADDR+1)'(1);
    localparam logic [ADDR:0]   CNT_FULL = (ADDR+1)'(DEPTH);

    logic [ADDR-1:0]  tos, tos_nxt;
    logic [ADDR:0]    count, count_nxt;
    logic [WIDTH-1:0] top, top_nxt;
    logic             ovf, ovf_nxt;
    logic             unf, unf_nxt;
    logic             accept;

`ifdef RAS_CKPT_EN
    typedef enum logic {RUN, REFILL} state_t;
    state_t          state, state_nxt;
    logic [ADDR-1:0] ckpt_tos;
    logic [ADDR:0]   ckpt_count;

    assign bus.ready = (state == RUN);
`else
    logic unused_doa;
    assign unused_doa = ^bram_doa;
    assign bus.ready  = 1'b1;
`endif

    assign bus.top_addr  = top;
    assign bus.top_valid = (count != '0);
    assign bus.overflow  = ovf;
    assign bus.underflow = unf;
    assign bram_web      = 1'b0;
    assign bram_waddrb   = '0;
    assign bram_wib      = '0;

    // Next-state logic: a restore or refill pre-empts the stack operation;
    // port B always prefetches the entry just below the next top so a pop
    // next cycle finds its new top already on bram_dob.
    always_comb begin
        tos_nxt     = tos;
        count_nxt   = count;
        top_nxt     = top;
        ovf_nxt     = 1'b0;
        unf_nxt     = 1'b0;
        accept      = 1'b1;
        bram_rea    = 1'b0;
        bram_raddra = '0;
        bram_wea    = 1'b0;
        bram_waddra = '0;
        bram_wia    = '0;
`ifdef RAS_CKPT_EN
        state_nxt   = state;
        if (state == REFILL) begin
            accept    = 1'b0;
            top_nxt   = bram_doa;
            state_nxt = RUN;
        end else if (ckpt_restore) begin
            accept      = 1'b0;
            tos_nxt     = ckpt_tos;
            count_nxt   = ckpt_count;
            bram_rea    = 1'b1;
            bram_raddra = ckpt_tos;
            state_nxt   = REFILL;
        end
`endif
        if (accept) begin
            if (bus.push && (!bus.pop || count == '0)) begin
                bram_wea    = 1'b1;
                bram_waddra = tos + TOS_ONE;
                bram_wia    = bus.push_addr;
                tos_nxt     = tos + TOS_ONE;
                top_nxt     = bus.push_addr;
                if (count == CNT_FULL) ovf_nxt = 1'b1;
                else                   count_nxt = count + CNT_ONE;
            end else if (bus.push && bus.pop) begin
                bram_wea    = 1'b1;
                bram_waddra = tos;
                bram_wia    = bus.push_addr;
                top_nxt     = bus.push_addr;
            end else if (bus.pop) begin
                if (count == '0) begin
                    unf_nxt = 1'b1;
                end else begin
                    tos_nxt   = tos - TOS_ONE;
                    count_nxt = count - CNT_ONE;
                    top_nxt   = bram_dob;
                end
            end
        end
        bram_reb    = 1'b1;
        bram_raddrb = tos_nxt - TOS_ONE;
        if (rst) begin
            bram_rea = 1'b0;
            bram_reb = 1'b0;
            bram_wea = 1'b0;
        end
    end

    // State register; RAM contents are left alone on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos   <= '0;
            count <= '0;
            top   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            tos   <= tos_nxt;
            count <= count_nxt;
            top   <= top_nxt;
            ovf   <= ovf_nxt;
            unf   <= unf_nxt;
        end
    end

`ifdef RAS_CKPT_EN
    // Checkpoint captures pre-operation pointers; a simultaneous restore drops the save.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            ckpt_tos   <= '0;
            ckpt_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == RUN && ckpt_save && !ckpt_restore) begin
                ckpt_tos   <= tos;
                ckpt_count <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: scoreboard bench for ras_ctrl with a BRAM model and a
// queue-based stack reference; checkpoint tests run when RAS_CKPT_EN is defined.
module tb_ras_ctrl;
    localparam int DEPTH = 4;
    localparam int WIDTH = 36;
    localparam int ADDR  = $clog2(DEPTH);

    typedef struct {
        logic [WIDTH-1:0] top;
        bit               topKnown;
        bit               valid;
        bit               ovf;
        bit               unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    ras_if #(.WIDTH(WIDTH)) bus();

    logic             bram_rea, bram_reb, bram_wea, bram_web;
    logic [ADDR-1:0]  bram_raddra, bram_raddrb, bram_waddra, bram_waddrb;
    logic [WIDTH-1:0] bram_wia, bram_wib, bram_doa, bram_dob;
    logic [WIDTH-1:0] ram [DEPTH];

`ifdef RAS_CKPT_EN
    logic ckptSave = 1'b0;
    logic ckptRestore = 1'b0;
`endif

    int               compared = 0;
    int               mismatched = 0;
    bit               opValid = 1'b0;
    bit               sampledOp = 1'b0;
    exp_t             expQ[$];
    exp_t             e;
    logic [WIDTH-1:0] model[$];
    logic [WIDTH-1:0] expTop = '0;
    bit               expKnown = 1'b1;

    ras_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
`ifdef RAS_CKPT_EN
        .ckpt_save   (ckptSave),
        .ckpt_restore(ckptRestore),
`endif
        .bram_rea    (bram_rea),
        .bram_reb    (bram_reb),
        .bram_wea    (bram_wea),
        .bram_web    (bram_web),
        .bram_raddra (bram_raddra),
        .bram_raddrb (bram_raddrb),
        .bram_waddra (bram_waddra),
        .bram_waddrb (bram_waddrb),
        .bram_wia    (bram_wia),
        .bram_wib    (bram_wib),
        .bram_doa    (bram_doa),
        .bram_dob    (bram_dob)
    );

    always #5 clk = ~clk;

    // Dual-port BRAM with one-cycle registered reads.
    always @(posedge clk) begin
        if (bram_wea) ram[bram_waddra] <= bram_wia;
        if (bram_rea) bram_doa <= ram[bram_raddra];
        if (bram_reb) bram_dob <= ram[bram_raddrb];
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference stack: a bounded queue whose back is the top and whose front
    // is the oldest entry (dropped when a push lands on a full stack).
    task automatic applyStimulus(input bit p, input bit q, input logic [WIDTH-1:0] a);
        exp_t x;
        @(negedge clk);
        bus.push = p;
        bus.pop = q;
        bus.push_addr = a;
        opValid = 1'b1;
        x.ovf = 1'b0;
        x.unf = 1'b0;
        if (p && (!q || model.size() == 0)) begin
            if (model.size() == DEPTH) begin
                x.ovf = 1'b1;
                void'(model.pop_front());
            end
            model.push_back(a);
            expTop = a;
            expKnown = 1'b1;
        end else if (p && q) begin
            model[model.size()-1] = a;
            expTop = a;
            expKnown = 1'b1;
        end else if (q) begin
            if (model.size() == 0) begin
                x.unf = 1'b1;
            end else begin
                void'(model.pop_back());
                if (model.size() > 0) expTop = model[model.size()-1];
                else expKnown = 1'b0;
            end
        end
        x.top = expTop;
        x.topKnown = expKnown;
        x.valid = (model.size() != 0);
        expQ.push_back(x);
    endtask

    task automatic idleCycle();
        @(negedge clk);
        bus.push = 1'b0;
        bus.pop = 1'b0;
        opValid = 1'b0;
    endtask

    task automatic doReset();
        idleCycle();
        idleCycle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model.delete();
        expTop = '0;
        expKnown = 1'b1;
    endtask

    always @(posedge clk) sampledOp <= opValid && !rst;

    // Monitor: every output cycle following a driven operation is checked
    // against the oldest queued expectation.
    always @(negedge clk) begin
        if (sampledOp) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL scoreboard_empty: got an output cycle, expected a queued entry");
            end else begin
                e = expQ.pop_front();
                checkOutput("top_valid", 64'(bus.top_valid), 64'(e.valid));
                checkOutput("overflow", 64'(bus.overflow), 64'(e.ovf));
                checkOutput("underflow", 64'(bus.underflow), 64'(e.unf));
                checkOutput("ready", 64'(bus.ready), 64'd1);
                if (e.topKnown) checkOutput("top_addr", 64'(bus.top_addr), 64'(e.top));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0]      r64;
        logic [WIDTH-1:0] a;
        int               r;
        logic [WIDTH-1:0] savedStack[$];

        rst = 1'b1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.push_addr = '0;
        #1;
        checkOutput("reset_top_addr", 64'(bus.top_addr), 64'd0);
        checkOutput("reset_top_valid", 64'(bus.top_valid), 64'd0);
        checkOutput("reset_overflow", 64'(bus.overflow), 64'd0);
        checkOutput("reset_underflow", 64'(bus.underflow), 64'd0);
        checkOutput("reset_ready", 64'(bus.ready), 64'd1);
        checkOutput("reset_enables", 64'({bram_rea, bram_reb, bram_wea, bram_web}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Pop while empty, then an idle cycle to confirm the pulse is single.
        applyStimulus(0, 1, '0);
        applyStimulus(0, 0, '0);
        // Three pushes then three back-to-back pops.
        applyStimulus(1, 0, 36'h100);
        applyStimulus(1, 0, 36'h200);
        applyStimulus(1, 0, 36'h300);
        applyStimulus(0, 1, '0);
        applyStimulus(0, 1, '0);
        applyStimulus(0, 1, '0);
        // Overflow on the fifth push into a four-entry stack.
        for (int i = 1; i <= 5; i++) applyStimulus(1, 0, WIDTH'(i));
        applyStimulus(0, 0, '0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, '0);
        // Replace, then drain.
        applyStimulus(1, 0, 36'hA);
        applyStimulus(1, 1, 36'hB);
        applyStimulus(0, 1, '0);
        applyStimulus(1, 1, 36'hC);
        applyStimulus(0, 1, '0);

        for (int i = 0; i < 400; i++) begin
            r64 = {$urandom, $urandom};
            a = r64[WIDTH-1:0];
            r = $urandom_range(0, 9);
            if (r < 4)      applyStimulus(1, 0, a);
            else if (r < 7) applyStimulus(0, 1, '0);
            else if (r < 9) applyStimulus(1, 1, a);
            else            applyStimulus(0, 0, '0);
        end

`ifdef RAS_CKPT_EN
        doReset();
        applyStimulus(1, 0, WIDTH'(1));
        applyStimulus(1, 0, WIDTH'(2));
        applyStimulus(0, 0, '0);
        ckptSave = 1'b1;
        savedStack = model;
        applyStimulus(1, 0, WIDTH'(3));
        ckptSave = 1'b0;
        applyStimulus(0, 1, '0);
        applyStimulus(0, 1, '0);
        idleCycle();
        idleCycle();
        @(negedge clk);
        ckptRestore = 1'b1;
        @(negedge clk);
        ckptRestore = 1'b0;
        checkOutput("ckpt_ready_refill", 64'(bus.ready), 64'd0);
        @(negedge clk);
        checkOutput("ckpt_ready_after", 64'(bus.ready), 64'd1);
        checkOutput("ckpt_top_addr", 64'(bus.top_addr), 64'd2);
        checkOutput("ckpt_top_valid", 64'(bus.top_valid), 64'd1);
        model = savedStack;
        expTop = WIDTH'(2);
        expKnown = 1'b1;
        applyStimulus(0, 1, '0);
        applyStimulus(0, 1, '0);
        applyStimulus(0, 0, '0);
        idleCycle();
        idleCycle();
        // Reset asserted in the middle of a REFILL cycle.
        @(negedge clk);
        ckptRestore = 1'b1;
        @(negedge clk);
        ckptRestore = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_refill_ready", 64'(bus.ready), 64'd1);
        checkOutput("rst_refill_top_addr", 64'(bus.top_addr), 64'd0);
        checkOutput("rst_refill_top_valid", 64'(bus.top_valid), 64'd0);
        checkOutput("rst_refill_pulses", 64'({bus.overflow, bus.underflow}), 64'd0);
        checkOutput("rst_refill_enables", 64'({bram_rea, bram_reb, bram_wea}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_refill_ready_edge", 64'(bus.ready), 64'd1);
        model.delete();
        expTop = '0;
        expKnown = 1'b1;
        applyStimulus(0, 1, '0);
`endif

        idleCycle();
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Return-address-stack controller that sits directly upstream of the dual-port RAS block RAM and drives all of its ports. It accepts call (push) and return (pop) requests from the branch predictor and keeps the top-of-stack pointer and occupancy count. It caches the top entry in a register, so the predicted return address is available with zero read latency. It also schedules BRAM reads so that back-to-back pops sustain one operation per cycle.

## Interface
- DEPTH, 1024: stack entries; must be a power of two. ADDR = $clog2(DEPTH).
- WIDTH, 36: return-address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  call: push push_addr.
- pop  in  1  return: pop the top entry.
- push_addr  in  WIDTH  address to push.
- ready  out  1  request accepted this cycle. Tied to 1 unless the checkpoint feature is compiled in.
- top_addr  out  WIDTH  current top entry (registered); this is the predicted return address.
- top_valid  out  1  count != 0.
- overflow  out  1  one-cycle pulse: a push at full overwrote the oldest entry.
- underflow  out  1  one-cycle pulse: a pop occurred while empty.
- bram_rea, bram_reb, bram_wea, bram_web  out  1  BRAM enables.
- bram_raddra, bram_raddrb, bram_waddra, bram_waddrb  out  ADDR  BRAM addresses.
- bram_wia, bram_wib  out  WIDTH  BRAM write data. bram_web is always 0 and bram_wib is always 0.
- bram_doa, bram_dob  in  WIDTH  BRAM read data, valid one cycle after the enable.

## Operation
- State:
  - tos: ADDR-bit pointer; wraps modulo DEPTH.
  - count: 0..DEPTH, saturating.
  - top register: holds the same value as ram[tos].
- Push only:
  - Write port A: bram_waddra = tos+1, bram_wia = push_addr.
  - tos++, top_addr <= push_addr, count = min(count+1, DEPTH).
  - If count == DEPTH, pulse overflow; the oldest entry is silently overwritten.
- Pop only:
  - The popped value is top_addr in the pop cycle.
  - tos--, top_addr <= bram_dob, count--.
  - If count == 0: tos, count and top_addr are unchanged; pulse underflow.
- Push and pop in the same cycle (replace):
  - Write ram[tos] = push_addr; top_addr <= push_addr; tos and count unchanged.
  - If the stack is empty, this is treated as a plain push. Neither pulse fires.
- Below-top prefetch:
  - Every accepted cycle asserts bram_reb, with bram_raddrb = next_tos-1, where next_tos is the tos value after this cycle.
  - This guarantees bram_dob equals ram[tos-1] in the following cycle.
  - A port-B read never targets the address written on port A in the same cycle.
- Pop taking count from 1 to 0: top_addr takes whatever bram_dob holds (stale data), and top_valid drops to 0.
- Reset: tos = 0, count = 0, top_addr = 0, top_valid = 0, overflow = 0, underflow = 0, ready = 1, all BRAM enables 0, FSM in RUN. RAM contents are not touched.

## Timing
- top_addr, top_valid and count reflect an operation one cycle after it is accepted.
- Sustained throughput is one push, pop or replace per cycle, with no bubbles.
- Requests made while ready = 0 are ignored; the requester must hold them.
- rst asserted at any point, including during REFILL, returns all state to reset values immediately.

## Configuration
- RAS_CKPT_EN defined: enables checkpoint and restore for misprediction recovery.
  - Adds inputs ckpt_save and ckpt_restore (1 bit each).
  - ckpt_save latches the pre-operation tos and count.
  - ckpt_restore performs the following in the restore cycle:
    - loads tos and count from the checkpoint;
    - issues reads bram_raddra = ckpt_tos and bram_raddrb = ckpt_tos-1;
    - ignores any push or pop in the same cycle;
    - moves the FSM from RUN to REFILL.
  - REFILL lasts one cycle: ready = 0, top_addr <= bram_doa, then return to RUN.
  - If ckpt_restore and ckpt_save are asserted together, the restore wins and the save is dropped.
  - Restoring a checkpoint with count 0 still passes through REFILL; top_valid = 0 afterwards.
  - The checkpoint registers reset to tos 0, count 0.
- RAS_CKPT_EN undefined:
  - The ckpt ports are absent and there is no REFILL state.
  - ready is constant 1 and bram_rea is constant 0.

## Test plan
- Reset, then push 0x100, 0x200, 0x300 in consecutive cycles, then pop three times in consecutive cycles.
  - Required: top_addr reads 0x300, 0x200, 0x100 in the pop cycles, with no bubbles.
  - Required: top_valid = 0 afterwards.
- Pop while empty.
  - Required: underflow pulses for exactly 1 cycle; count stays 0 and top_addr stays 0.
- With DEPTH = 4, push 1, 2, 3, 4, 5.
  - Required: overflow pulses on the push of 5.
  - Then pop 4 times: values are 5, 4, 3, 2.
- Push 0xA, then push+pop 0xB together.
  - Required: top_addr = 0xB and count = 1.
  - A following pop returns 0xB and leaves the stack empty.
- RAS_CKPT_EN build: push 1, 2; save; push 3; pop; pop; restore.
  - Required: ready = 0 for 1 cycle, then top_addr = 2 and count = 2.
- Assert rst during REFILL.
  - Required: all outputs return to reset values in the same cycle, and ready = 1 on the next edge.
